// File: rtl/tc_pkg.sv
// Shared definitions for the memory-mapped timer: FSM states, register offsets,
// CTRL bit positions and mode codes.
package tc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } tcState_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    localparam logic [1:0] MODE_ONESHOT    = 2'b00;
    localparam logic [1:0] MODE_AUTORELOAD = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and IRQ.
// Auto-reload mode is built only when TIMER_AUTORELOAD_EN is defined.
module timer_counter
    import tc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       preset;
    logic [31:0]       count;
    logic              irqPend;
    tcState_e          state, stateNext;

    logic       ctrlWr, presetWr;
    logic       en, im, autoReload;
    logic [1:0] mode;

    assign ctrlWr   = sel & we & (addr == ADDR_CTRL);
    assign presetWr = sel & we & (addr == ADDR_PRESET);
    assign en       = ctrl[CTRL_EN];
    assign im       = ctrl[CTRL_IM];
    assign mode     = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];

`ifdef TIMER_AUTORELOAD_EN
    assign autoReload = (mode == MODE_AUTORELOAD);
`else
    assign autoReload = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: stateNext = en ? LOAD : IDLE;
            LOAD: stateNext = en ? CNT : IDLE;
            CNT: begin
                if (!en)             stateNext = IDLE;
                else if (count == 0) stateNext = INT;
                else                 stateNext = CNT;
            end
            INT:  stateNext = autoReload ? LOAD : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // A CPU CTRL write in the INT cycle overrides the one-shot EN clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl <= '0;
        end else if (ctrlWr) begin
            ctrl <= wdata[CTRL_W-1:0];
        end else if (state == INT && !autoReload) begin
            ctrl[CTRL_EN] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)         preset <= '0;
        else if (presetWr) preset <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (state == LOAD) begin
            count <= preset;
        end else if (state == CNT && en && count != 0) begin
            count <= count - 32'd1;
        end
    end

    // Auto-reload always passes through LOAD right after INT, which ends its pulse;
    // a one-shot pending bit only reaches LOAD after a CTRL write has cleared it.
    always_ff @(posedge clk) begin
        if (reset)               irqPend <= 1'b0;
        else if (ctrlWr)         irqPend <= 1'b0;
        else if (state == INT)   irqPend <= 1'b1;
        else if (state == LOAD)  irqPend <= 1'b0;
    end

    assign irq = irqPend & im;

    always_comb begin
        rdata = '0;
        unique case (addr)
            ADDR_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl};
            ADDR_PRESET: rdata = preset;
            ADDR_COUNT:  rdata = count;
            default:     rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: expectations are queued per cycle from
// the documented timeline and drained against register reads and irq.
`timescale 1ns/100ps
module tb_timer_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        string       tag;
        bit          isIrq;
        logic [1:0]  a;
        logic [31:0] exp;
    } sbEntry_t;

    sbEntry_t sb[$];

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pushRd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        sbEntry_t e;
        e.tag = tag; e.isIrq = 1'b0; e.a = a; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pushIrq(input string tag, input logic exp);
        sbEntry_t e;
        e.tag = tag; e.isIrq = 1'b1; e.a = 2'd0; e.exp = {31'd0, exp};
        sb.push_back(e);
    endtask

    // Keep at most a few entries queued per cycle so sampling stays before the next edge.
    task automatic drain();
        sbEntry_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.isIrq) begin
                checkEq(e.tag, {31'd0, irq}, e.exp);
            end else begin
                addr = e.a;
                #1;
                checkEq(e.tag, rdata, e.exp);
            end
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        cyc();
        sel = 1'b0; we = 1'b0; wdata = '0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state, and unmapped/read-only writes are ignored.
        pushRd("rst_ctrl", 2'd0, 32'h0);
        pushRd("rst_preset", 2'd1, 32'h0);
        pushRd("rst_count", 2'd2, 32'h0);
        pushRd("rst_off3", 2'd3, 32'h0);
        pushIrq("rst_irq", 1'b0);
        drain();
        wr(2'd3, 32'hDEAD_BEEF);
        wr(2'd2, 32'h1234);
        wr(2'd0, 32'hFFFF_FFF0);
        pushRd("off3_ro", 2'd3, 32'h0);
        pushRd("count_ro", 2'd2, 32'h0);
        pushRd("ctrl_hi_ignored", 2'd0, 32'h0);
        drain();

        // One-shot, PRESET=3: irq rises after edge 7 and holds.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 9; k++) begin
            logic [31:0] expCnt;
            cyc();
            case (k)
                1: expCnt = 32'd0;
                2: expCnt = 32'd3;
                3: expCnt = 32'd2;
                4: expCnt = 32'd1;
                default: expCnt = 32'd0;
            endcase
            pushRd($sformatf("os_count_e%0d", k), 2'd2, expCnt);
            pushIrq($sformatf("os_irq_e%0d", k), k >= 7);
            drain();
        end
        pushRd("os_ctrl_en_cleared", 2'd0, 32'h8);
        drain();
        wr(2'd0, 32'h0);
        pushIrq("os_irq_cleared", 1'b0);
        drain();

        // PRESET=0 still walks LOAD->CNT->INT: irq after edge 4.
        doReset();
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            pushIrq($sformatf("p0_irq_e%0d", k), k >= 4);
            drain();
        end

        // MODE 01, PRESET=2: pulses every 5 cycles with the macro, single held irq without.
        doReset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 17; k++) begin
            cyc();
`ifdef TIMER_AUTORELOAD_EN
            pushIrq($sformatf("ar_irq_e%0d", k), (k == 6) || (k == 11) || (k == 16));
`else
            pushIrq($sformatf("ar_irq_e%0d", k), k >= 6);
`endif
            drain();
        end
`ifdef TIMER_AUTORELOAD_EN
        pushRd("ar_ctrl", 2'd0, 32'hB);
`else
        pushRd("ar_ctrl", 2'd0, 32'hA);
`endif
        drain();

        // IM=0, PRESET=10: disable lands as COUNT reaches 5, freezing it there.
        doReset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) cyc();
        pushRd("fr_count_before", 2'd2, 32'd6);
        drain();
        wr(2'd0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            pushRd($sformatf("fr_count_%0d", k), 2'd2, 32'd5);
            pushIrq($sformatf("fr_irq_%0d", k), 1'b0);
            drain();
        end
        wr(2'd2, 32'h55);
        pushRd("fr_count_ro", 2'd2, 32'd5);
        pushRd("fr_preset", 2'd1, 32'd10);
        drain();

        // PRESET=8 counting, reset at COUNT=4 aborts the period.
        wr(2'd1, 32'd8);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 6; k++) cyc();
        pushRd("ab_count_before", 2'd2, 32'd4);
        drain();
        doReset();
        pushRd("ab_ctrl", 2'd0, 32'h0);
        pushRd("ab_preset", 2'd1, 32'h0);
        pushRd("ab_count", 2'd2, 32'h0);
        pushIrq("ab_irq", 1'b0);
        drain();
        for (int k = 0; k < 12; k++) begin
            cyc();
            pushIrq($sformatf("ab_irq_after_%0d", k), 1'b0);
            drain();
        end
        pushRd("ab_count_idle", 2'd2, 32'h0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
